// File: rtl/demux_1to4_stream.sv
// Registered 1-to-4 stream demultiplexer.
// Each channel has a one-entry output register, its own handshake and a delivery counter.
module demux_1to4_stream #(
  parameter int DATA_W = 8
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [DATA_W-1:0]   in_data,
  input  logic [1:0]          in_sel,
  output logic [3:0]          out_valid,
  input  logic [3:0]          out_ready,
  output logic [4*DATA_W-1:0] out_data,
  input  logic                cnt_clr,
  output logic [31:0]         cnt
);

  logic [3:0] ld;
  logic [3:0] xfer;
  logic       take;

  // Ready only looks at the addressed channel, never at in_valid.
  assign in_ready = !out_valid[in_sel] | out_ready[in_sel];
  assign take     = in_valid & in_ready;
  assign ld       = {4{take}} & (4'b0001 << in_sel);
  assign xfer     = out_valid & out_ready;

  for (genvar k = 0; k < 4; k++) begin : g_ch
    logic              vld;
    logic [DATA_W-1:0] dat;
    logic [7:0]        num;

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld <= 1'b0;
        dat <= '0;
      end else if (ld[k]) begin
        vld <= 1'b1;
        dat <= in_data;
      end else if (xfer[k]) begin
        vld <= 1'b0;
      end
    end

    // Clear wins over a same-cycle delivery.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        num <= '0;
      end else if (cnt_clr) begin
        num <= '0;
      end else if (xfer[k]) begin
        num <= num + 8'd1;
      end
    end

    assign out_valid[k]                  = vld;
    assign out_data[k*DATA_W +: DATA_W] = dat;
    assign cnt[k*8 +: 8]                 = num;
  end

endmodule

// File: tb/tb_demux_1to4_stream.sv
// Bench for demux_1to4_stream: directed table, corner sequences
// and random traffic against a word-level channel model.
module tb_demux_1to4_stream;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [7:0]  in_data;
  logic [1:0]  in_sel;
  logic [3:0]  out_valid;
  logic [3:0]  out_ready;
  logic [31:0] out_data;
  logic        cnt_clr;
  logic [31:0] cnt;

  int n_chk;
  int n_pass;

  demux_1to4_stream #(.DATA_W(8)) dut (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_data(in_data),
    .in_sel(in_sel),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .cnt_clr(cnt_clr),
    .cnt(cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // model: each channel either holds a word or not, plus a delivery tally
  bit       m_full [4];
  int       m_word [4];
  int       m_cnt  [4];

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic model_reset();
    for (int k = 0; k < 4; k++) begin
      m_full[k] = 0;
      m_word[k] = 0;
      m_cnt[k]  = 0;
    end
  endtask

  function automatic bit model_ready(int s);
    return !m_full[s] || out_ready[s];
  endfunction

  task automatic cmp_state(string tag);
    logic [3:0]  ev;
    logic [31:0] ed;
    logic [31:0] ec;
    for (int k = 0; k < 4; k++) begin
      ev[k]        = m_full[k];
      ed[k*8 +: 8] = 8'(m_word[k]);
      ec[k*8 +: 8] = 8'(m_cnt[k] % 256);
    end
    chk({tag, ".valid"}, {28'd0, out_valid}, {28'd0, ev});
    chk({tag, ".data"}, out_data, ed);
    chk({tag, ".cnt"}, cnt, ec);
  endtask

  // one clock: check ready, advance model, edge, compare
  task automatic step(string tag);
    bit acc;
    #1;
    chk({tag, ".ready"}, {31'd0, in_ready}, {31'd0, model_ready(int'(in_sel))});
    acc = in_valid && model_ready(int'(in_sel));
    for (int k = 0; k < 4; k++) begin
      bit gone;
      gone = m_full[k] && out_ready[k];
      if (cnt_clr) m_cnt[k] = 0;
      else if (gone) m_cnt[k] = m_cnt[k] + 1;
      if (gone) m_full[k] = 0;
      if (acc && int'(in_sel) == k) begin
        m_full[k] = 1;
        m_word[k] = int'(in_data);
      end
    end
    @(posedge clk);
    #1;
    cmp_state(tag);
  endtask

  task automatic drive(bit v, int s, int d, logic [3:0] r, bit c);
    in_valid  = v;
    in_sel    = 2'(s);
    in_data   = 8'(d);
    out_ready = r;
    cnt_clr   = c;
  endtask

  typedef struct {
    bit         v;
    int         sel;
    int         dat;
    logic [3:0] rdy;
    bit         e_rdy;
    logic [3:0] e_ov;
    int         e_ch;
    int         e_dat;
  } vec_t;

  vec_t tbl [12];

  initial begin
    n_chk = 0;
    n_pass = 0;

    tbl[0]  = '{1, 2, 'hA5, 4'hF, 1, 4'b0100, 2, 'hA5};
    tbl[1]  = '{0, 2, 'h00, 4'hF, 1, 4'b0000, 2, 'hA5};
    tbl[2]  = '{1, 1, 'h11, 4'hD, 1, 4'b0010, 1, 'h11};
    tbl[3]  = '{1, 1, 'h22, 4'hD, 0, 4'b0010, 1, 'h11};
    tbl[4]  = '{1, 3, 'h33, 4'hD, 1, 4'b1010, 3, 'h33};
    tbl[5]  = '{1, 1, 'h22, 4'hF, 1, 4'b0010, 1, 'h22};
    tbl[6]  = '{0, 0, 'h00, 4'hF, 1, 4'b0000, 1, 'h22};
    tbl[7]  = '{1, 0, 'h01, 4'hF, 1, 4'b0001, 0, 'h01};
    tbl[8]  = '{1, 0, 'h02, 4'hF, 1, 4'b0001, 0, 'h02};
    tbl[9]  = '{1, 0, 'h03, 4'hF, 1, 4'b0001, 0, 'h03};
    tbl[10] = '{1, 0, 'h04, 4'hF, 1, 4'b0001, 0, 'h04};
    tbl[11] = '{0, 0, 'h00, 4'hF, 1, 4'b0000, 0, 'h04};

    // reset and idle
    model_reset();
    drive(0, 0, 0, 4'h0, 0);
    rst_n = 1'b0;
    #12;
    chk("rst.valid", {28'd0, out_valid}, 32'd0);
    chk("rst.cnt", cnt, 32'd0);
    chk("rst.data", out_data, 32'd0);
    chk("rst.ready", {31'd0, in_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    step("idle");
    step("idle2");

    // directed table
    for (int i = 0; i < 12; i++) begin
      string nm;
      nm = $sformatf("tbl%0d", i);
      drive(tbl[i].v, tbl[i].sel, tbl[i].dat, tbl[i].rdy, 0);
      #1;
      chk({nm, ".rdy"}, {31'd0, in_ready}, {31'd0, tbl[i].e_rdy});
      step(nm);
      chk({nm, ".ov"}, {28'd0, out_valid}, {28'd0, tbl[i].e_ov});
      chk({nm, ".dat"}, {24'd0, out_data[tbl[i].e_ch*8 +: 8]},
          32'(tbl[i].e_dat));
    end
    chk("tbl.cnt", cnt, 32'h01010204);

    // clear, then wrap channel 3
    drive(0, 0, 0, 4'h0, 1);
    step("clr");
    chk("clr.cnt", cnt, 32'd0);
    for (int i = 0; i < 256; i++) begin
      drive(1, 3, i, 4'hF, 0);
      step("wrap");
    end
    drive(0, 0, 0, 4'hF, 0);
    step("wrap.end");
    chk("wrap.cnt3", {24'd0, cnt[31:24]}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      drive(1, 3, 'h40 + i, 4'hF, 0);
      step("more");
    end
    drive(0, 0, 0, 4'hF, 0);
    step("more.end");
    chk("more.cnt3", {24'd0, cnt[31:24]}, 32'd3);
    drive(1, 3, 'h77, 4'hF, 0);
    step("clrx.ld");
    drive(0, 0, 0, 4'hF, 1);
    step("clrx");
    chk("clrx.cnt3", {24'd0, cnt[31:24]}, 32'd0);

    // random traffic
    for (int i = 0; i < 3000; i++) begin
      drive($urandom_range(0, 1), $urandom_range(0, 3), $urandom_range(0, 255),
            4'($urandom_range(0, 15)), $urandom_range(0, 31) == 0);
      step("rnd");
    end

    // async reset while channels 0 and 2 are full
    drive(1, 0, 'hC0, 4'h0, 0);
    step("ar0");
    drive(1, 2, 'hC2, 4'h0, 0);
    step("ar2");
    chk("ar.full", {28'd0, out_valid & 4'b0101}, 32'd5);
    #3;
    rst_n = 1'b0;
    #1;
    chk("ar.valid", {28'd0, out_valid}, 32'd0);
    chk("ar.cnt", cnt, 32'd0);
    chk("ar.ready", {31'd0, in_ready}, 32'd1);
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(0, 0, 0, 4'h0, 0);
    step("ar.after");

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
